calc_arbiter: RTL

CALC_ARBITER -- requirements
Module: calc_arbiter

---
 rtl/calc_pkg.sv | 24 ++
 rtl/calc_rr_arbiter.sv | 36 +++
 rtl/calc_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arbiter slice.
//   calc_state_e : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   DATA_W       : width of operands, op codes and results
//   LAT_W        : width of the latency down-counter (covers 1..15)
//   OP_*         : calculator op code values understood by the calculator
package calc_pkg;

  localparam int DATA_W = 8;
  localparam int LAT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } calc_state_e;

  localparam logic [DATA_W-1:0] OP_ADD = 8'h00;
  localparam logic [DATA_W-1:0] OP_SUB = 8'h01;
  localparam logic [DATA_W-1:0] OP_AND = 8'h02;
  localparam logic [DATA_W-1:0] OP_OR  = 8'h03;
  localparam logic [DATA_W-1:0] OP_XOR = 8'h04;

endpackage

// File: rtl/calc_rr_arbiter.sv
// Combinational round-robin winner selection.
//   req_valid : per-requester request vector
//   rr_ptr    : index where the search starts (wraps modulo NUM_REQ)
//   grant     : one-hot winner, all zero when nobody requests
//   grant_idx : binary index of the winner (0 when nobody requests)
module calc_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] idx_c;

  // Walk the requesters starting at rr_ptr; the first valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx_c     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_c = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[idx_c]) begin
        found        = 1'b1;
        grant[idx_c] = 1'b1;
        grant_idx    = idx_c;
      end
    end
  end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one multi-cycle calculator between NUM_REQ requesters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester request handshake
//   req_operand_a/b     : packed operands, requester i at [8i+7:8i]
//   req_op_code         : packed op codes, same packing
//   rsp_valid           : one-cycle result strobe to the owning requester
//   rsp_result          : captured calculator result
//   operand_A/B, op_code: registered drive to the calculator
//   calc_start          : one-cycle launch pulse to the calculator
//   result              : calculator result (opaque)
//   busy                : high whenever the FSM is not idle
//   grant_id            : current / last owner index
//   state_dbg           : FSM state for observation
//
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready is only ever high in IDLE and only
// on the round-robin winner. Requesters hold req_valid until accepted.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CALC_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_operand_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_operand_b,
  input  logic [NUM_REQ*DATA_W-1:0]   req_op_code,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_result,
  output logic [DATA_W-1:0]           operand_A,
  output logic [DATA_W-1:0]           operand_B,
  output logic [DATA_W-1:0]           op_code,
  output logic                        calc_start,
  input  logic [DATA_W-1:0]           result,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [1:0]                  state_dbg
);

  localparam int IDX_W = $clog2(NUM_REQ);

  calc_state_e        state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic [LAT_W-1:0]   lat_cnt;
  logic               handshake;

  calc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // The winner is always a valid requester, so any request in IDLE transfers.
  assign handshake = (state == ST_IDLE) && (|req_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (handshake) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (lat_cnt == LAT_W'(1)) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operands are latched at the handshake and then held untouched
  // until the next handshake, so the calculator sees stable inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_A  <= '0;
      operand_B  <= '0;
      op_code    <= '0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      lat_cnt    <= '0;
      rsp_result <= '0;
    end else begin
      if (handshake) begin
        operand_A <= req_operand_a[{arb_idx, 3'b000} +: DATA_W];
        operand_B <= req_operand_b[{arb_idx, 3'b000} +: DATA_W];
        op_code   <= req_op_code[{arb_idx, 3'b000} +: DATA_W];
        grant_id  <= arb_idx;
        rr_ptr    <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end
      if (state == ST_ISSUE) begin
        lat_cnt <= LAT_W'(CALC_LATENCY);
      end else if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      // Last WAIT cycle: the calculator result is valid now.
      if ((state == ST_WAIT) && (lat_cnt == LAT_W'(1))) begin
        rsp_result <= result;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == ST_IDLE) req_ready = arb_grant;
    if (state == ST_RESP) rsp_valid[grant_id] = 1'b1;
  end

  assign calc_start = (state == ST_ISSUE);
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;

endmodule
